// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for the instruction memory write port
//
// Stream: LEN_LO, LEN_HI (N lines, 1..512), 16*N data bytes, XOR checksum byte.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   start             begin a load (honoured in IDLE, DONE, ERR only)
//   rx_data/rx_valid  incoming byte and its valid flag
//   rx_ready          byte accepted this cycle when rx_valid is also high
//   imem_addr         line address (line counter)
//   imem_wdata        assembled 128-bit line, byte k at bits [8k+7:8k]
//   imem_we           one-cycle write strobe per line
//   busy              load in progress (HDR0 through CSUM)
//   done              one-cycle pulse after a good checksum
//   err               bad length or checksum, held until start or reset
module imem_loader (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [8:0]   imem_addr,
  output logic [127:0] imem_wdata,
  output logic         imem_we,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int INSN_LEN = 32;
  localparam int LINE_W   = 4 * INSN_LEN;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [9:0]          r_len;
  logic [8:0]          r_line;
  logic [3:0]          r_byte;
  logic [7:0]          r_csum;
  logic [LINE_W-1:0]   r_buf;

  logic                w_accept;
  logic [15:0]         w_hdr_n;
  logic                w_len_ok;
  logic                w_last_line;

  assign w_accept    = rx_valid && rx_ready;
  // Full 16-bit header value so that any nonzero high bits are caught as too long.
  assign w_hdr_n     = {rx_data, r_len[7:0]};
  assign w_len_ok    = (w_hdr_n != 16'd0) && (w_hdr_n <= 16'd512);
  // r_len >= 1 whenever this is used, so the subtraction never underflows.
  assign w_last_line = ({1'b0, r_line} == (r_len - 10'd1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_HDR0;
      S_DONE:  w_next = start ? S_HDR0 : S_IDLE;
      S_ERR:   if (start) w_next = S_HDR0;
      S_HDR0:  if (w_accept) w_next = S_HDR1;
      S_HDR1:  if (w_accept) w_next = w_len_ok ? S_DATA : S_ERR;
      S_DATA:  if (w_accept && (r_byte == 4'd15)) w_next = S_WRITE;
      S_WRITE: w_next = w_last_line ? S_CSUM : S_DATA;
      S_CSUM:  if (w_accept) w_next = (rx_data == r_csum) ? S_DONE : S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state only
  always_comb begin
    rx_ready = 1'b0;
    imem_we  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (r_state)
      S_HDR0, S_HDR1, S_DATA, S_CSUM: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      S_WRITE: begin
        imem_we = 1'b1;
        busy    = 1'b1;
      end
      S_DONE:  done = 1'b1;
      S_ERR:   err  = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr  = r_line;
  assign imem_wdata = r_buf;

  // Datapath: length, counters, line buffer and running checksum
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len  <= '0;
      r_line <= '0;
      r_byte <= '0;
      r_csum <= '0;
      r_buf  <= '0;
    end else begin
      case (r_state)
        S_HDR0: if (w_accept) r_len <= {2'b00, rx_data};
        S_HDR1: if (w_accept) begin
          r_len  <= w_hdr_n[9:0];
          r_line <= '0;
          r_byte <= '0;
          r_csum <= '0;
        end
        S_DATA: if (w_accept) begin
          r_buf[{r_byte, 3'b000} +: 8] <= rx_data;
          r_csum <= r_csum ^ rx_data;
          r_byte <= r_byte + 4'd1;
        end
        S_WRITE: begin
          r_byte <= '0;
          if (!w_last_line) r_line <= r_line + 9'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
module tb_imem_loader;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic         rx_ready;
  logic [8:0]   imem_addr;
  logic [127:0] imem_wdata;
  logic         imem_we;
  logic         busy;
  logic         done;
  logic         err;

  int total = 0;
  int bad = 0;

  logic [7:0]   data_b[$];
  logic [8:0]   obs_addr[$];
  logic [127:0] obs_data[$];
  int           done_cnt = 0;
  int           viol_cnt = 0;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .imem_we    (imem_we),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Observer: records every memory write and done pulse, flags ready during a write
  always @(negedge clk) begin
    if (imem_we) begin
      obs_addr.push_back(imem_addr);
      obs_data.push_back(imem_wdata);
      if (rx_ready) viol_cnt++;
    end
    if (done) done_cnt++;
  end

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
    done_cnt = 0;
    viol_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered and left at a negedge; waits a bounded time for acceptance.
  task automatic send_byte(input logic [7:0] b, input int gapmax);
    int n;
    int t;
    n = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
    repeat (n) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (!rx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      total++;
      bad++;
      $display("FAIL send_byte_timeout: rx_ready=%0b required 1", rx_ready);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Drives a full stream from data_b; checksum is the XOR of the data bytes, then flipped.
  task automatic run_stream(input int nlines, input logic [7:0] flip, input int gap);
    logic [7:0] x;
    x = 8'h00;
    pulse_start();
    send_byte(nlines[7:0], gap);
    send_byte(8'(nlines >> 8), gap);
    for (int i = 0; i < nlines * 16; i++) begin
      send_byte(data_b[i], gap);
      x ^= data_b[i];
    end
    send_byte(x ^ flip, gap);
    repeat (3) @(negedge clk);
  endtask

  task automatic fill_random(input int nlines);
    data_b.delete();
    for (int i = 0; i < nlines * 16; i++) data_b.push_back(8'($urandom));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({rx_ready, imem_we, busy, done, err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b required 00000", {rx_ready, imem_we, busy, done, err});
    end
    total++;
    if (imem_addr !== 9'd0 || imem_wdata !== 128'd0) begin
      bad++;
      $display("FAIL reset_bus: addr=%h wdata=%h required 0", imem_addr, imem_wdata);
    end
    reset = 1'b0;
    @(negedge clk);
    clear_obs();
  endtask

  task automatic test_single_line();
    logic [127:0] exp;
    data_b.delete();
    for (int i = 0; i < 16; i++) data_b.push_back(8'(i));
    clear_obs();
    pulse_start();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_start: got %b required 1", busy);
    end
    repeat (2) @(negedge clk);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 16; i++) send_byte(data_b[i], 0);
    send_byte(8'h00, 0);
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL single_done_timing: got %b required 1", done);
    end
    repeat (3) @(negedge clk);
    exp = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    total++;
    if (obs_addr.size() != 1 || obs_addr[0] !== 9'd0 || obs_data[0] !== exp) begin
      bad++;
      $display("FAIL single_write: count=%0d addr=%h data=%h required 1/0/%h",
               obs_addr.size(), obs_addr.size() ? obs_addr[0] : 9'h0,
               obs_data.size() ? obs_data[0] : 128'h0, exp);
    end
    total++;
    if (done_cnt != 1 || err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_status: done_cnt=%0d err=%b busy=%b required 1/0/0", done_cnt, err, busy);
    end
  endtask

  // Compares the recorded writes against the lines packed from data_b.
  task automatic test_random_lines(input int nlines, input int gap, input string tag);
    logic [127:0] exp;
    fill_random(nlines);
    clear_obs();
    run_stream(nlines, 8'h00, gap);
    total++;
    if (obs_addr.size() != nlines) begin
      bad++;
      $display("FAIL %s_count: got %0d required %0d", tag, obs_addr.size(), nlines);
    end
    for (int l = 0; l < nlines && l < obs_addr.size(); l++) begin
      for (int k = 0; k < 16; k++) exp[8*k +: 8] = data_b[16*l + k];
      total++;
      if (obs_addr[l] !== 9'(l) || obs_data[l] !== exp) begin
        bad++;
        $display("FAIL %s_line%0d: addr=%h data=%h required %h/%h",
                 tag, l, obs_addr[l], obs_data[l], 9'(l), exp);
      end
    end
    total++;
    if (done_cnt != 1 || err !== 1'b0 || viol_cnt != 0) begin
      bad++;
      $display("FAIL %s_status: done_cnt=%0d err=%b ready_in_write=%0d required 1/0/0",
               tag, done_cnt, err, viol_cnt);
    end
  endtask

  task automatic test_bad_header();
    clear_obs();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    total++;
    if (err !== 1'b1 || rx_ready !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL hdr_zero: err=%b rx_ready=%b busy=%b required 1/0/0", err, rx_ready, busy);
    end
    repeat (3) @(negedge clk);
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL err_held: got %b required 1", err);
    end
    pulse_start();
    total++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL err_clear_on_start: err=%b busy=%b required 0/1", err, busy);
    end
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    total++;
    if (err !== 1'b1 || rx_ready !== 1'b0) begin
      bad++;
      $display("FAIL hdr_513: err=%b rx_ready=%b required 1/0", err, rx_ready);
    end
    repeat (2) @(negedge clk);
    total++;
    if (obs_addr.size() != 0 || done_cnt != 0) begin
      bad++;
      $display("FAIL hdr_no_write: writes=%0d done_cnt=%0d required 0/0", obs_addr.size(), done_cnt);
    end
    test_random_lines(1, 1, "after_err");
  endtask

  task automatic test_bad_checksum();
    fill_random(2);
    clear_obs();
    run_stream(2, 8'h01, 1);
    total++;
    if (obs_addr.size() != 2 || done_cnt != 0 || err !== 1'b1) begin
      bad++;
      $display("FAIL bad_csum: writes=%0d done_cnt=%0d err=%b required 2/0/1",
               obs_addr.size(), done_cnt, err);
    end
  endtask

  task automatic test_full_depth();
    logic [127:0] exp;
    int mism;
    data_b.delete();
    for (int l = 0; l < 512; l++)
      for (int k = 0; k < 16; k++) data_b.push_back(8'(l));
    clear_obs();
    run_stream(512, 8'h00, 0);
    total++;
    if (obs_addr.size() != 512 || obs_addr[obs_addr.size()-1] !== 9'd511) begin
      bad++;
      $display("FAIL full_last: count=%0d last_addr=%h required 512/1ff",
               obs_addr.size(), obs_addr.size() ? obs_addr[obs_addr.size()-1] : 9'h0);
    end
    mism = 0;
    for (int l = 0; l < obs_addr.size() && l < 512; l++) begin
      for (int k = 0; k < 16; k++) exp[8*k +: 8] = 8'(l);
      if (obs_addr[l] !== 9'(l) || obs_data[l] !== exp) mism++;
    end
    total++;
    if (mism != 0) begin
      bad++;
      $display("FAIL full_lines: mismatching lines=%0d required 0", mism);
    end
    total++;
    if (done_cnt != 1 || err !== 1'b0) begin
      bad++;
      $display("FAIL full_status: done_cnt=%0d err=%b required 1/0", done_cnt, err);
    end
  endtask

  task automatic test_start_ignored();
    logic [7:0]   x;
    logic [127:0] exp;
    fill_random(1);
    clear_obs();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    x = 8'h00;
    for (int i = 0; i < 5; i++) begin
      send_byte(data_b[i], 0);
      x ^= data_b[i];
    end
    pulse_start();
    total++;
    if (busy !== 1'b1 || rx_ready !== 1'b1) begin
      bad++;
      $display("FAIL start_mid_load: busy=%b rx_ready=%b required 1/1", busy, rx_ready);
    end
    for (int i = 5; i < 16; i++) begin
      send_byte(data_b[i], 0);
      x ^= data_b[i];
    end
    send_byte(x, 0);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 16; k++) exp[8*k +: 8] = data_b[k];
    total++;
    if (obs_addr.size() != 1 || obs_data[0] !== exp || done_cnt != 1) begin
      bad++;
      $display("FAIL start_ignored_result: writes=%0d data=%h done_cnt=%0d required 1/%h/1",
               obs_addr.size(), obs_data.size() ? obs_data[0] : 128'h0, done_cnt, exp);
    end
  endtask

  task automatic test_reset_mid_line();
    fill_random(2);
    clear_obs();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 24; i++) send_byte(data_b[i], 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (busy !== 1'b0 || rx_ready !== 1'b0 || imem_addr !== 9'd0 || imem_wdata !== 128'd0) begin
      bad++;
      $display("FAIL reset_mid: busy=%b rx_ready=%b addr=%h wdata=%h required 0/0/0/0",
               busy, rx_ready, imem_addr, imem_wdata);
    end
    repeat (3) @(negedge clk);
    total++;
    if (obs_addr.size() != 1 || obs_addr[0] !== 9'd0) begin
      bad++;
      $display("FAIL reset_partial_line: writes=%0d required 1", obs_addr.size());
    end
    test_random_lines(1, 2, "post_reset");
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_random_lines(3, 3, "rand3");
    test_bad_header();
    test_bad_checksum();
    test_full_depth();
    test_start_ignored();
    test_reset_mid_line();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
